// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready timeout trap.
// Optional BEQ support is compiled in when MIPS_CTRL_BRANCH_EN is defined.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic [1:0] fault
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_R   = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    fault_q, fault_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_wait_s;
  logic          timeout_s;

`ifndef MIPS_CTRL_BRANCH_EN
  logic unused_zero_s;
  assign unused_zero_s = zero;
`endif

  // Memory wait detection and timeout expiry; mem_ready always wins over expiry.
  always_comb begin
    mem_wait_s = 1'b0;
    if ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) begin
      mem_wait_s = !mem_ready;
    end else begin
      mem_wait_s = 1'b0;
    end
    timeout_s = (MEM_TIMEOUT != 0) && mem_wait_s && (wait_cnt_q == CW'(MEM_TIMEOUT - 1));
  end

  // Next-state, fault and wait counter computation.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_EXEC_R;
          OP_LW:    state_d = S_ADDR;
          OP_SW:    state_d = S_ADDR;
`ifdef MIPS_CTRL_BRANCH_EN
          OP_BEQ:   state_d = S_BRANCH;
`endif
          default: begin
            state_d = S_TRAP;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_ADDR: begin
        if (opcode == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timeout_s) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end else begin
          state_d = state_q;
        end
      end
      S_WB_MEM: state_d = S_FETCH;
`ifdef MIPS_CTRL_BRANCH_EN
      S_BRANCH: state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        fault_d = FAULT_ILLEGAL;
      end
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait_s && !(&wait_cnt_q)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, fault and wait counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fault_q    <= FAULT_NONE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Control outputs decoded from the current state; everything is held low during reset.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    state      = 4'd0;
    fault      = FAULT_NONE;
    if (!rst) begin
      state = state_q;
      fault = fault_q;
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC_R: alu_op = 3'b010;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          alu_op    = 3'b010;
        end
        S_ADDR: alu_src = 1'b1;
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
`ifdef MIPS_CTRL_BRANCH_EN
        S_BRANCH: begin
          alu_op   = 3'b001;
          pc_write = zero;
          pc_src   = 1'b1;
        end
`endif
        default: mem_read = 1'b0;
      endcase
    end else begin
      state = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl (MEM_TIMEOUT=4); BEQ vectors follow MIPS_CTRL_BRANCH_EN.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, reg_dst, alu_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [1:0] fault;

  int n_vec = 0;
  int n_err = 0;

  // {mem_read,mem_write,iord,ir_write,pc_write,pc_src,reg_write,mem_to_reg,reg_dst,alu_src,alu_op}
  localparam logic [12:0] C_ZERO   = 13'b0_0_0_0_0_0_0_0_0_0_000;
  localparam logic [12:0] C_FET_R  = 13'b1_0_0_1_1_0_0_0_0_0_000;
  localparam logic [12:0] C_FET_W  = 13'b1_0_0_0_0_0_0_0_0_0_000;
  localparam logic [12:0] C_EXEC   = 13'b0_0_0_0_0_0_0_0_0_0_010;
  localparam logic [12:0] C_WB_R   = 13'b0_0_0_0_0_0_1_0_1_0_010;
  localparam logic [12:0] C_ADDR   = 13'b0_0_0_0_0_0_0_0_0_1_000;
  localparam logic [12:0] C_MEMRD  = 13'b1_0_1_0_0_0_0_0_0_0_000;
  localparam logic [12:0] C_MEMWR  = 13'b0_1_1_0_0_0_0_0_0_0_000;
  localparam logic [12:0] C_WB_MEM = 13'b0_0_0_0_0_0_1_1_0_0_000;
  localparam logic [12:0] C_BR_Z1  = 13'b0_0_0_0_1_1_0_0_0_0_001;
  localparam logic [12:0] C_BR_Z0  = 13'b0_0_0_0_0_1_0_0_0_0_001;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BAD = 6'b111111;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge, check outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic z,
                     input logic [3:0] es, input logic [12:0] ec, input logic [1:0] ef);
    opcode = op; mem_ready = rdy; zero = z;
    #1;
    check_eq({tag, ".state"}, {12'd0, state}, {12'd0, es});
    check_eq({tag, ".ctrl"}, {3'd0, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
              reg_write, mem_to_reg, reg_dst, alu_src, alu_op}, {3'd0, ec});
    check_eq({tag, ".fault"}, {14'd0, fault}, {14'd0, ef});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("reset", OP_SW, 1'b1, 1'b1, 4'd0, C_ZERO, 2'b00);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    cyc("r.fetch",  OP_R,  1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("r.decode", OP_R,  1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    cyc("r.exec",   OP_R,  1'b1, 1'b0, 4'd2, C_EXEC,  2'b00);
    cyc("r.wb",     OP_R,  1'b1, 1'b0, 4'd6, C_WB_R,  2'b00);

    cyc("lw.fetch",  OP_LW, 1'b1, 1'b0, 4'd0, C_FET_R,  2'b00);
    cyc("lw.decode", OP_LW, 1'b1, 1'b0, 4'd1, C_ZERO,   2'b00);
    cyc("lw.addr",   OP_LW, 1'b1, 1'b0, 4'd3, C_ADDR,   2'b00);
    cyc("lw.memrd",  OP_LW, 1'b1, 1'b0, 4'd4, C_MEMRD,  2'b00);
    cyc("lw.wb",     OP_LW, 1'b1, 1'b0, 4'd7, C_WB_MEM, 2'b00);

    cyc("sw.fetch",  OP_SW, 1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("sw.decode", OP_SW, 1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    cyc("sw.addr",   OP_SW, 1'b1, 1'b0, 4'd3, C_ADDR,  2'b00);
    cyc("sw.memwr",  OP_SW, 1'b1, 1'b0, 4'd5, C_MEMWR, 2'b00);

    // LW with three wait cycles in MEM_RD: eight cycles total.
    cyc("lww.fetch",  OP_LW, 1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("lww.decode", OP_LW, 1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    cyc("lww.addr",   OP_LW, 1'b1, 1'b0, 4'd3, C_ADDR,  2'b00);
    for (int i = 0; i < 3; i++) cyc("lww.wait", OP_LW, 1'b0, 1'b0, 4'd4, C_MEMRD, 2'b00);
    cyc("lww.memrd",  OP_LW, 1'b1, 1'b0, 4'd4, C_MEMRD,  2'b00);
    cyc("lww.wb",     OP_LW, 1'b1, 1'b0, 4'd7, C_WB_MEM, 2'b00);

    // Ready arrives on the 4th wait cycle: no trap.
    for (int i = 0; i < 3; i++) cyc("edge.wait", OP_R, 1'b0, 1'b0, 4'd0, C_FET_W, 2'b00);
    cyc("edge.ready",  OP_R, 1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("edge.decode", OP_R, 1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    cyc("edge.exec",   OP_R, 1'b1, 1'b0, 4'd2, C_EXEC,  2'b00);
    cyc("edge.wb",     OP_R, 1'b1, 1'b0, 4'd6, C_WB_R,  2'b00);

    // Illegal opcode traps and stays trapped.
    cyc("ill.fetch",  OP_BAD, 1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("ill.decode", OP_BAD, 1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    for (int i = 0; i < 3; i++) cyc("ill.trap", OP_R, 1'b1, 1'b0, 4'd9, C_ZERO, 2'b01);
    do_reset();

`ifdef MIPS_CTRL_BRANCH_EN
    cyc("beq1.fetch",  OP_BEQ, 1'b1, 1'b1, 4'd0, C_FET_R, 2'b00);
    cyc("beq1.decode", OP_BEQ, 1'b1, 1'b1, 4'd1, C_ZERO,  2'b00);
    cyc("beq1.branch", OP_BEQ, 1'b1, 1'b1, 4'd8, C_BR_Z1, 2'b00);
    cyc("beq0.fetch",  OP_BEQ, 1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("beq0.decode", OP_BEQ, 1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    cyc("beq0.branch", OP_BEQ, 1'b1, 1'b0, 4'd8, C_BR_Z0, 2'b00);
    cyc("beq.next",    OP_R,   1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
`else
    cyc("beq.fetch",  OP_BEQ, 1'b1, 1'b1, 4'd0, C_FET_R, 2'b00);
    cyc("beq.decode", OP_BEQ, 1'b1, 1'b1, 4'd1, C_ZERO,  2'b00);
    cyc("beq.trap",   OP_BEQ, 1'b1, 1'b1, 4'd9, C_ZERO,  2'b01);
`endif
    do_reset();

    // Memory stuck in FETCH: trap after four wait cycles, sticky until reset.
    for (int i = 0; i < 4; i++) cyc("to.wait", OP_R, 1'b0, 1'b0, 4'd0, C_FET_W, 2'b00);
    for (int i = 0; i < 3; i++) cyc("to.trap", OP_R, 1'b1, 1'b0, 4'd9, C_ZERO, 2'b10);
    do_reset();

    // Reset in the middle of a stalled store drops mem_write at once.
    cyc("rsw.fetch",  OP_SW, 1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);
    cyc("rsw.decode", OP_SW, 1'b1, 1'b0, 4'd1, C_ZERO,  2'b00);
    cyc("rsw.addr",   OP_SW, 1'b1, 1'b0, 4'd3, C_ADDR,  2'b00);
    cyc("rsw.wait",   OP_SW, 1'b0, 1'b0, 4'd5, C_MEMWR, 2'b00);
    do_reset();
    cyc("rsw.after",  OP_R,  1'b1, 1'b0, 4'd0, C_FET_R, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS core. It replaces single-cycle opcode decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared instruction/data memory port with a ready handshake and traps on an illegal opcode or on a memory timeout. It sits between the instruction register and the datapath muxes, register file, ALU and memory port.

## Interface
- `MEM_TIMEOUT`, default 16: maximum wait cycles for `mem_ready` per access; 0 disables the timeout.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction[31:26] from the IR, valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `iord` out 1: address select; 0 = PC, 1 = ALU result.
- `ir_write` out 1: load the IR from memory data.
- `pc_write` out 1: update the PC.
- `pc_src` out 1: PC source; 0 = PC+4, 1 = branch target.
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 1: writeback source; 1 = memory data, 0 = ALU.
- `reg_dst` out 1: destination register; 1 = rd, 0 = rt.
- `alu_src` out 1: ALU operand B; 1 = sign-extended immediate, 0 = rt.
- `alu_op` out 3: 000 = ADD, 001 = SUB, 010 = decode by funct.
- `state` out 4: current state encoding, for debug.
- `fault` out 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.

## Operation
- **States and encodings:** FETCH 0, DECODE 1, EXEC_R 2, ADDR 3, MEM_RD 4, MEM_WR 5, WB_R 6, WB_MEM 7, BRANCH 8, TRAP 9.
- **Outputs:** combinational from `state`, with `mem_ready`/`zero` qualifiers where stated. Any output not listed for a state is 0.
- **FETCH:** `mem_read`=1, `iord`=0. When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then → DECODE. Otherwise stay in FETCH.
- **DECODE:** no strobes. Next state by opcode:
  - 000000 → EXEC_R
  - 100011 (LW) → ADDR
  - 101011 (SW) → ADDR
  - 000100 (BEQ) → BRANCH, only when the macro below is defined
  - anything else → TRAP, `fault`=01
- **EXEC_R:** `alu_src`=0, `alu_op`=010 → WB_R.
- **WB_R:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `alu_op`=010 → FETCH.
- **ADDR:** `alu_src`=1, `alu_op`=000. → MEM_RD for LW, MEM_WR for SW. The opcode is held in the IR.
- **MEM_RD:** `mem_read`=1, `iord`=1. When `mem_ready`=1 → WB_MEM.
- **MEM_WR:** `mem_write`=1, `iord`=1. When `mem_ready`=1 → FETCH.
- **WB_MEM:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- **Timeout counter:**
  - `wait_cnt` is $clog2(MEM_TIMEOUT+1) bits wide.
  - It clears on every state change and increments each cycle spent in FETCH/MEM_RD/MEM_WR with `mem_ready`=0.
  - If `wait_cnt`==MEM_TIMEOUT-1 and `mem_ready`=0 → TRAP with `fault`=10.
  - `mem_ready` wins in the same cycle the counter would expire.
  - The counter saturates and never wraps.
- **TRAP:** all strobes are 0 and `fault` is held. TRAP is sticky; only `rst` exits it.
- **Reset:** while `rst`=1, all outputs are forced to 0 and `fault`=00; on the following edge `state`=FETCH and `wait_cnt`=0. A reset mid-access abandons the access; no write is completed after reset is asserted.

## Timing
- With zero-wait memory (`mem_ready`=1 in the strobe cycle), cycles per instruction are:
  - R-type: 4 (FETCH, DECODE, EXEC_R, WB_R)
  - LW: 5
  - SW: 4
  - BEQ: 3
- Each wait cycle adds exactly one cycle.
- `pc_write`/`ir_write` last exactly one cycle per fetch.
- `reg_write` lasts exactly one cycle per R-type or LW instruction.
- `mem_write` stays high throughout MEM_WR until `mem_ready` is sampled.
- The first fetch strobe appears in the first cycle after `rst` deasserts.

## Configuration
- **`MIPS_CTRL_BRANCH_EN` defined:**
  - BEQ is legal.
  - BRANCH state asserts `alu_src`=0 and `alu_op`=001.
  - `pc_write`=`zero`, `pc_src`=1, then → FETCH.
- **`MIPS_CTRL_BRANCH_EN` undefined:** the BRANCH state is not built, and opcode 000100 traps with `fault`=01.

## Test plan
- **Reset:** `rst` held 3 cycles → all outputs 0 during reset; cycle after release: `state`=0, `mem_read`=1, `iord`=0.
- **Zero-wait mix:** R-type, LW, SW, each with `mem_ready`=1 → state sequences 0,1,2,6 / 0,1,3,4,7 / 0,1,3,5. `reg_write` pulses once for R-type and once for LW, never for SW.
- **Wait states:** LW with `mem_ready` low for 3 cycles in MEM_RD → `mem_read`/`iord` held 4 cycles; WB_MEM follows; total 8 cycles.
- **Timeout:** `MEM_TIMEOUT`=4, `mem_ready` stuck 0 in FETCH → TRAP after 4 cycles with `fault`=10, strobes 0. Stays in TRAP until `rst`.
- **Timeout edge:** `mem_ready`=1 exactly on the 4th wait cycle → no trap; proceeds to DECODE.
- **BEQ with `MIPS_CTRL_BRANCH_EN`:**
  - opcode 000100, `zero`=1 → `pc_write`=1, `pc_src`=1 in BRANCH.
  - `zero`=0 → `pc_write`=0.
  - Macro undefined → `fault`=01.
  - Opcode 111111 → `fault`=01 in either build.
